// File: rtl/nmr_bstrm_seq_loader.sv
// Sequence loader for the NMR bitstream counter: checks host command words, writes
// legal ones into the command SRAM, and fires one START per ARM of a loaded sequence.
module nmr_bstrm_seq_loader #(
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH  = 32,
  parameter int DATA_WIDTH      = 24,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [SRAM_DAT_WIDTH-1:0]  CMD_DAT,
  input  logic                       CMD_VLD,
  output logic                       CMD_RDY,
  input  logic                       ARM,
  input  logic                       CLR,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_WR_ADDR,
  output logic [SRAM_DAT_WIDTH-1:0]  SRAM_WR_DAT,
  output logic                       SRAM_WR_EN,
  output logic                       BSTRM_START,
  input  logic                       BSTRM_DONE,
  output logic                       LOADED,
  output logic                       BUSY,
  output logic                       ERR,
  output logic [2:0]                 ERR_CODE,
  output logic [SRAM_ADDR_WIDTH:0]   WORD_CNT,
  output logic [CNT_WIDTH-1:0]       RUN_CNT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADED = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_STA_BAD  = 3'd1;
  localparam logic [2:0] E_STO_BAD  = 3'd2;
  localparam logic [2:0] E_OPEN_END = 3'd3;
  localparam logic [2:0] E_OVERFLOW = 3'd4;
  localparam logic [2:0] E_LEN_ZERO = 3'd5;

  state_t                     r_state;
  logic [SRAM_ADDR_WIDTH-1:0] r_wr_ptr;
  logic                       r_loop_open;

  logic       w_xfer;
  logic       w_seq_end;
  logic       w_loop_sta;
  logic       w_loop_sto;
  logic       w_len_zero;
  logic       w_open_after;
  logic       w_ptr_last;
  logic [2:0] w_err_code;

  assign w_xfer       = CMD_VLD & CMD_RDY;
  assign w_seq_end    = CMD_DAT[30];
  assign w_loop_sta   = CMD_DAT[29];
  assign w_loop_sto   = CMD_DAT[28];
  assign w_len_zero   = (CMD_DAT[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
  assign w_open_after = w_loop_sto ? 1'b0 : (r_loop_open | w_loop_sta);
  assign w_ptr_last   = &r_wr_ptr;

  // Structural check of the offered word, highest-priority cause first
  always_comb begin
    w_err_code = E_NONE;
    if (w_loop_sta && (w_loop_sto || r_loop_open)) begin
      w_err_code = E_STA_BAD;
    end else if (w_loop_sto && !r_loop_open) begin
      w_err_code = E_STO_BAD;
    end else if (w_len_zero) begin
      w_err_code = E_LEN_ZERO;
    end else if (w_seq_end && w_open_after) begin
      w_err_code = E_OPEN_END;
    end else if (w_ptr_last && !w_seq_end) begin
      w_err_code = E_OVERFLOW;
    end else begin
      w_err_code = E_NONE;
    end
  end

  // Loader FSM with all outputs registered alongside the state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_loop_open  <= 1'b0;
      CMD_RDY      <= 1'b1;
      SRAM_WR_ADDR <= '0;
      SRAM_WR_DAT  <= '0;
      SRAM_WR_EN   <= 1'b0;
      BSTRM_START  <= 1'b0;
      LOADED       <= 1'b0;
      BUSY         <= 1'b0;
      ERR          <= 1'b0;
      ERR_CODE     <= E_NONE;
      WORD_CNT     <= '0;
      RUN_CNT      <= '0;
    end else if (CLR) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_loop_open <= 1'b0;
      CMD_RDY     <= 1'b1;
      SRAM_WR_EN  <= 1'b0;
      BSTRM_START <= 1'b0;
      LOADED      <= 1'b0;
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
      ERR_CODE    <= E_NONE;
      WORD_CNT    <= '0;
      RUN_CNT     <= '0;
    end else begin
      SRAM_WR_EN  <= 1'b0;
      BSTRM_START <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && (w_err_code == E_NONE)) begin
            SRAM_WR_EN   <= 1'b1;
            SRAM_WR_ADDR <= r_wr_ptr;
            SRAM_WR_DAT  <= CMD_DAT;
            r_wr_ptr     <= r_wr_ptr + SRAM_ADDR_WIDTH'(1);
            WORD_CNT     <= WORD_CNT + (SRAM_ADDR_WIDTH + 1)'(1);
            r_loop_open  <= w_open_after;
            if (w_seq_end) begin
              r_state <= S_LOADED;
              CMD_RDY <= 1'b0;
              LOADED  <= 1'b1;
            end
          end else if (w_xfer) begin
            r_state  <= S_ERROR;
            CMD_RDY  <= 1'b0;
            ERR      <= 1'b1;
            ERR_CODE <= w_err_code;
          end
        end
        S_LOADED: begin
          if (ARM) begin
            r_state     <= S_START;
            BSTRM_START <= 1'b1;
            LOADED      <= 1'b0;
          end
        end
        S_START: begin
          r_state <= S_RUN;
          BUSY    <= 1'b1;
        end
        S_RUN: begin
          if (BSTRM_DONE) begin
            r_state <= S_LOADED;
            BUSY    <= 1'b0;
            LOADED  <= 1'b1;
            RUN_CNT <= RUN_CNT + CNT_WIDTH'(1);
          end
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_ERROR;
          CMD_RDY <= 1'b0;
          LOADED  <= 1'b0;
          BUSY    <= 1'b0;
          ERR     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmr_bstrm_seq_loader.sv
// Scoreboard bench for nmr_bstrm_seq_loader: expected SRAM writes are queued at
// stimulus time and popped by write monitors; status outputs are checked directly.
module tb_nmr_bstrm_seq_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] CMD_DAT;
  logic        CMD_VLD, ARM, CLR, BSTRM_DONE;
  logic        CMD_RDY, SRAM_WR_EN, BSTRM_START, LOADED, BUSY, ERR;
  logic [7:0]  SRAM_WR_ADDR;
  logic [31:0] SRAM_WR_DAT;
  logic [2:0]  ERR_CODE;
  logic [8:0]  WORD_CNT;
  logic [15:0] RUN_CNT;

  logic [31:0] b_cmd_dat;
  logic        b_cmd_vld;
  logic        b_cmd_rdy, b_wr_en, b_start, b_loaded, b_busy, b_err;
  logic [2:0]  b_wr_addr;
  logic [31:0] b_wr_dat;
  logic [2:0]  b_err_code;
  logic [3:0]  b_word_cnt;
  logic [15:0] b_run_cnt;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [39:0] exp_a[$];
  logic [34:0] exp_b[$];

  always #5 CLK = ~CLK;

  nmr_bstrm_seq_loader dut_a (
    .CLK(CLK), .RST(RST), .CMD_DAT(CMD_DAT), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY),
    .ARM(ARM), .CLR(CLR), .SRAM_WR_ADDR(SRAM_WR_ADDR), .SRAM_WR_DAT(SRAM_WR_DAT),
    .SRAM_WR_EN(SRAM_WR_EN), .BSTRM_START(BSTRM_START), .BSTRM_DONE(BSTRM_DONE),
    .LOADED(LOADED), .BUSY(BUSY), .ERR(ERR), .ERR_CODE(ERR_CODE),
    .WORD_CNT(WORD_CNT), .RUN_CNT(RUN_CNT)
  );

  nmr_bstrm_seq_loader #(.SRAM_ADDR_WIDTH(3)) dut_b (
    .CLK(CLK), .RST(RST), .CMD_DAT(b_cmd_dat), .CMD_VLD(b_cmd_vld), .CMD_RDY(b_cmd_rdy),
    .ARM(1'b0), .CLR(1'b0), .SRAM_WR_ADDR(b_wr_addr), .SRAM_WR_DAT(b_wr_dat),
    .SRAM_WR_EN(b_wr_en), .BSTRM_START(b_start), .BSTRM_DONE(1'b0),
    .LOADED(b_loaded), .BUSY(b_busy), .ERR(b_err), .ERR_CODE(b_err_code),
    .WORD_CNT(b_word_cnt), .RUN_CNT(b_run_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Write monitor for the full-size instance
  always @(negedge CLK) begin
    if (SRAM_WR_EN === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_a_unexpected actual=0x%0h/0x%0h required=none", SRAM_WR_ADDR, SRAM_WR_DAT);
      end else begin
        chk("wr_a", {SRAM_WR_ADDR, SRAM_WR_DAT}, exp_a.pop_front());
      end
    end
  end

  // Write monitor for the 8-deep instance
  always @(negedge CLK) begin
    if (b_wr_en === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_b_unexpected actual=0x%0h/0x%0h required=none", b_wr_addr, b_wr_dat);
      end else begin
        chk("wr_b", {b_wr_addr, b_wr_dat}, exp_b.pop_front());
      end
    end
  end

  // START pulse counter
  always @(negedge CLK) begin
    if (BSTRM_START === 1'b1) start_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    CMD_DAT = w; CMD_VLD = 1'b1;
    cyc(1);
    CMD_VLD = 1'b0;
  endtask

  task automatic send_ok(input logic [31:0] w, input logic [7:0] addr);
    exp_a.push_back({addr, w});
    send(w);
  endtask

  task automatic pulse_arm();
    ARM = 1'b1; cyc(1); ARM = 1'b0;
  endtask

  task automatic pulse_done();
    BSTRM_DONE = 1'b1; cyc(1); BSTRM_DONE = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1; cyc(1); CLR = 1'b0;
  endtask

  logic [31:0] seq17 [17] = '{
    32'h8000000F, 32'h00000008, 32'h80000010, 32'h00000008, 32'h20000005,
    32'h80000009, 32'h00000009, 32'h80000009, 32'h00000009, 32'h80000009,
    32'h00000009, 32'h80000009, 32'h00000009, 32'h80000009, 32'h00000009,
    32'h10000009, 32'h40000010
  };

  initial begin
    RST = 1'b1; CMD_DAT = 32'h0; CMD_VLD = 1'b0; ARM = 1'b0; CLR = 1'b0;
    BSTRM_DONE = 1'b0; b_cmd_dat = 32'h0; b_cmd_vld = 1'b0;
    cyc(3);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_cmd_rdy", CMD_RDY, 1);
    chk("rst_wr", {SRAM_WR_EN, SRAM_WR_ADDR, SRAM_WR_DAT}, 0);
    chk("rst_flags", {BSTRM_START, LOADED, BUSY, ERR, ERR_CODE}, 0);
    chk("rst_cnts", {WORD_CNT, RUN_CNT}, 0);
    cyc(1);

    // 17-word load, back-to-back
    for (int i = 0; i < 17; i++) send_ok(seq17[i], 8'(i));
    @(negedge CLK);
    chk("load_loaded", LOADED, 1);
    chk("load_word_cnt", WORD_CNT, 17);
    chk("load_err", ERR, 0);
    chk("load_cmd_rdy", CMD_RDY, 0);
    send(32'h80000001);
    pulse_done();
    @(negedge CLK);
    chk("done_in_loaded", RUN_CNT, 0);

    // First run
    pulse_arm();
    @(negedge CLK);
    chk("run1_start", {BSTRM_START, BUSY}, 2'b10);
    cyc(1);
    @(negedge CLK);
    chk("run1_start_gone", {BSTRM_START, BUSY}, 2'b01);
    pulse_arm();
    cyc(47);
    chk("arm_in_run_ignored", start_cnt, 1);
    pulse_done();
    @(negedge CLK);
    chk("run1_done", {RUN_CNT, LOADED, BUSY}, {16'd1, 1'b1, 1'b0});

    // Re-arm in the cycle right after DONE
    pulse_arm();
    @(negedge CLK);
    chk("run2_start", BSTRM_START, 1);
    cyc(5);
    pulse_done();
    @(negedge CLK);
    chk("run2_done", {RUN_CNT, LOADED}, {16'd2, 1'b1});
    chk("start_cnt_2", start_cnt, 2);

    // CLR and ARM together in LOADED
    ARM = 1'b1; CLR = 1'b1; cyc(1); ARM = 1'b0; CLR = 1'b0;
    @(negedge CLK);
    chk("clr_arm_state", {CMD_RDY, LOADED, BSTRM_START}, 3'b100);
    chk("clr_arm_cnts", {WORD_CNT, RUN_CNT}, 0);
    cyc(3);
    chk("clr_arm_no_start", start_cnt, 2);

    // Stray loop_sto as first word
    send(32'h10000004);
    @(negedge CLK);
    chk("e2_err", {ERR, ERR_CODE, CMD_RDY}, {1'b1, 3'd2, 1'b0});
    chk("e2_word_cnt", WORD_CNT, 0);
    pulse_arm();
    cyc(2);
    chk("e2_arm_ignored", start_cnt, 2);
    pulse_clr();
    @(negedge CLK);
    chk("clr_err", {ERR, ERR_CODE, CMD_RDY, WORD_CNT}, {1'b0, 3'd0, 1'b1, 9'd0});

    // End with loop still open
    send_ok(32'h20000005, 8'd0);
    send(32'h40000010);
    @(negedge CLK);
    chk("e3_err", {ERR, ERR_CODE}, {1'b1, 3'd3});
    chk("e3_word_cnt", WORD_CNT, 1);
    pulse_clr();

    // Nested loop_sta
    send_ok(32'h20000001, 8'd0);
    send(32'h20000001);
    @(negedge CLK);
    chk("e1_nested", {ERR_CODE, WORD_CNT}, {3'd1, 9'd1});
    pulse_clr();
    send(32'h30000001);
    @(negedge CLK);
    chk("e1_sta_sto", ERR_CODE, 1);
    pulse_clr();
    send(32'h80000000);
    @(negedge CLK);
    chk("e5_len_zero", {ERR, ERR_CODE}, {1'b1, 3'd5});
    pulse_clr();

    // CLR during RUN abandons the run
    send_ok(32'h40000003, 8'd0);
    pulse_arm();
    cyc(2);
    chk("clr_run_busy", BUSY, 1);
    pulse_clr();
    @(negedge CLK);
    chk("clr_run", {BUSY, LOADED, BSTRM_START, CMD_RDY}, 4'b0001);
    chk("clr_run_starts", start_cnt, 3);

    // Reset mid-run, late DONE, reload
    send_ok(32'h40000003, 8'd0);
    pulse_arm();
    cyc(3);
    chk("rr_busy", BUSY, 1);
    RST = 1'b1; CLR = 1'b1; cyc(1); RST = 1'b0; CLR = 1'b0;
    @(negedge CLK);
    chk("rr_wr", {SRAM_WR_EN, SRAM_WR_ADDR, SRAM_WR_DAT}, 0);
    chk("rr_flags", {CMD_RDY, BSTRM_START, LOADED, BUSY, ERR, ERR_CODE}, 8'b1000_0000);
    pulse_done();
    @(negedge CLK);
    chk("rr_late_done", {RUN_CNT, BUSY}, 0);
    send_ok(32'h00000002, 8'd0);
    send_ok(32'h40000007, 8'd1);
    @(negedge CLK);
    chk("rr_reload", {LOADED, ERR, WORD_CNT}, {1'b1, 1'b0, 9'd2});

    // Overflow on the 8-deep instance
    for (int i = 0; i < 8; i++) begin
      if (i < 7) exp_b.push_back({3'(i), 32'h80000001});
      b_cmd_dat = 32'h80000001; b_cmd_vld = 1'b1;
      cyc(1);
    end
    b_cmd_vld = 1'b0;
    @(negedge CLK);
    chk("ovf_err", {b_err, b_err_code, b_cmd_rdy}, {1'b1, 3'd4, 1'b0});
    chk("ovf_word_cnt", b_word_cnt, 7);

    cyc(2);
    chk("wq_a_empty", exp_a.size(), 0);
    chk("wq_b_empty", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
